// File: rtl/pkt_buf_reader_if.sv
// Bus bundle for the packet buffer read engine: descriptor in, RAM read port, word stream out.
// master is the engine side, slave is the environment side (scheduler, RAM, egress sink).
interface pkt_buf_reader_if #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 12
);
  logic                  desc_valid;
  logic                  desc_ready;
  logic [ADDR_WIDTH-1:0] desc_addr;
  logic [LEN_WIDTH-1:0]  desc_len;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_WIDTH-1:0] ram_read_data;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;
  logic                  free_inc;
  logic                  busy;

  modport master (
    input  desc_valid, desc_addr, desc_len, ram_read_data, out_ready,
    output desc_ready, ram_addr, out_data, out_valid, out_last, free_inc, busy
  );

  modport slave (
    output desc_valid, desc_addr, desc_len, ram_read_data, out_ready,
    input  desc_ready, ram_addr, out_data, out_valid, out_last, free_inc, busy
  );
endinterface

// File: rtl/pkt_buf_reader.sv
// Packet buffer read engine: walks a descriptor's words through a 1-cycle-latency RAM port
// and streams them out via a 3-entry fall-through FIFO, returning one free credit per word.
module pkt_buf_reader #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int LEN_WIDTH  = 12
) (
  input  logic             clock,
  input  logic             reset,
  pkt_buf_reader_if.master bus
);
  typedef enum logic {IDLE, READ} state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, ram_addr_q;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_last_q;
  entry_t                fifo_q [3];
  logic [1:0]            rd_ptr_q, wr_ptr_q, count_q;
  logic                  accept, issue, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign bus.desc_ready = (state_q == IDLE) && !reset;
  assign accept         = bus.desc_valid && bus.desc_ready;
  // Reads in flight plus words buffered never exceed the 3 FIFO slots.
  assign issue          = (state_q == READ) && !reset &&
                          (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign push           = inflight_q;
  assign pop            = bus.out_valid && bus.out_ready;

  assign bus.ram_addr  = issue ? addr_q : ram_addr_q;
  assign bus.out_valid = (count_q != 2'd0) && !reset;
  assign bus.out_data  = bus.out_valid ? fifo_q[rd_ptr_q].data : '0;
  assign bus.out_last  = bus.out_valid && fifo_q[rd_ptr_q].last;
  assign bus.busy      = !reset && ((state_q == READ) || inflight_q || (count_q != 2'd0));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept && (bus.desc_len != '0)) begin
          state_d = READ;
          addr_d  = bus.desc_addr;
          rem_d   = bus.desc_len;
        end
      end
      READ: begin
        if (issue) begin
          rem_d  = rem_q - LEN_WIDTH'(1);
          addr_d = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      ram_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 2'd0;
      wr_ptr_q        <= 2'd0;
      count_q         <= 2'd0;
      bus.free_inc    <= 1'b0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      ram_addr_q      <= bus.ram_addr;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LEN_WIDTH'(1));
      bus.free_inc    <= pop;
      // Clearing inflight on reset is what drops data from reads issued before it.
      if (push) begin
        fifo_q[wr_ptr_q].data <= bus.ram_read_data;
        fifo_q[wr_ptr_q].last <= inflight_last_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && (count_q == 2'd3)));
endmodule

// File: tb/tb_pkt_buf_reader.sv
// Scoreboard bench for pkt_buf_reader: directed frames from the test plan, then random traffic.
module tb_pkt_buf_reader;
  localparam int WW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int LW    = 12;

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
    int            cyc;   // required output cycle, -1 when not timed
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pkt_buf_reader_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  pkt_buf_reader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [WW-1:0] mem [DEPTH];
  always @(posedge clock) bus.ram_read_data <= mem[bus.ram_addr];

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   rdy_mode = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Sink readiness: always, a 1,0,0 pattern, or random.
  initial begin
    int ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (rdy_mode)
        1: begin bus.out_ready = (ph == 0); ph = (ph + 1) % 3; end
        2: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks credits and stall stability.
  logic          prev_hs = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [WW-1:0] prev_data = '0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      check("free_inc", {31'd0, bus.free_inc}, {31'd0, prev_hs});
      if (prev_stall) begin
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_word", {23'd0, bus.out_data, bus.out_last}, {23'd0, prev_data, prev_last});
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, bus.out_data}, {24'd0, e.data});
          check("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
          if (e.cyc >= 0) check("out_cycle", cyc, e.cyc);
        end
      end
    end
    prev_hs    = !reset && bus.out_valid && bus.out_ready;
    prev_stall = !reset && bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
  end

  // Offers a descriptor until accepted; on acceptance the frame's words go on the scoreboard.
  task automatic send_desc(input int addr, input int len, input bit timed, output int acc);
    int n = 0;
    exp_t e;
    acc = -1;
    bus.desc_valid = 1'b1;
    bus.desc_addr  = AW'(addr);
    bus.desc_len   = LW'(len);
    forever begin
      @(negedge clock);
      if (bus.desc_ready) break;
      n++;
      if (n > 1000) begin
        check("desc_accept_timeout", n, 0);
        break;
      end
      @(posedge clock); #1;
    end
    if (n <= 1000) begin
      acc = cyc;
      for (int i = 0; i < len; i++) begin
        e.data = mem[(addr + i) % DEPTH];
        e.last = (i == len - 1);
        e.cyc  = timed ? acc + 3 + i : -1;
        exp_q.push_back(e);
      end
    end
    @(posedge clock); #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_timeout", {31'd0, (n >= 2000)}, 32'd0);
  endtask

  initial begin
    int acc1, acc2, base, n;
    logic [AW-1:0] saved_addr;
    bus.desc_valid = 1'b0;
    bus.desc_addr  = '0;
    bus.desc_len   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = WW'(i);

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("desc_ready_in_reset", {31'd0, bus.desc_ready}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_desc_ready", {31'd0, bus.desc_ready}, 32'd1);
    check("rst_ram_addr", {24'd0, bus.ram_addr}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    check("rst_free_inc", {31'd0, bus.free_inc}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clock); #1;

    // Single timed frame
    send_desc(8'h10, 4, 1'b1, acc1);
    wait_idle();

    // Address wrap
    send_desc(8'hFE, 4, 1'b1, acc1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("wrap_ram_addr", {24'd0, bus.ram_addr}, (254 + i) % DEPTH);
    end
    @(posedge clock); #1;
    wait_idle();

    // Backpressure
    rdy_mode = 1;
    send_desc(8'h60, 8, 1'b0, acc1);
    wait_idle();
    rdy_mode = 0;
    @(posedge clock); #1;

    // Back-to-back descriptors
    send_desc(8'h20, 3, 1'b1, acc1);
    send_desc(8'h40, 2, 1'b1, acc2);
    check("b2b_accept_cycle", acc2, acc1 + 4);
    wait_idle();

    // Zero length
    saved_addr = bus.ram_addr;
    send_desc(8'h33, 0, 1'b0, acc1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("zero_desc_ready", {31'd0, bus.desc_ready}, 32'd1);
      check("zero_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("zero_ram_addr", {24'd0, bus.ram_addr}, {24'd0, saved_addr});
    end
    @(posedge clock); #1;

    // Reset mid-frame after 3 handshakes
    base = hs_cnt;
    send_desc(8'h50, 10, 1'b0, acc1);
    n = 0;
    while (hs_cnt < base + 3 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("reset_wait_timeout", {31'd0, (n >= 100)}, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("postrst_desc_ready", {31'd0, bus.desc_ready}, 32'd1);
    check("postrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("postrst_busy", {31'd0, bus.busy}, 32'd0);
    check("postrst_ram_addr", {24'd0, bus.ram_addr}, 32'd0);
    @(posedge clock); #1;
    send_desc(8'h05, 2, 1'b1, acc1);
    wait_idle();

    // Random traffic with random RAM contents and a random sink
    for (int i = 0; i < DEPTH; i++) mem[i] = WW'($urandom);
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      send_desc($urandom_range(0, DEPTH - 1), $urandom_range(0, 12), 1'b0, acc1);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    wait_idle();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
